ixc_sfifo_reader: RTL and testbench

- Consumer end of the host-to-DUT input stream FIFO.
- The host writes message words into a circular buffer and publishes a 64-bit write count, wrCnt.
- This block reads the buffer, parses each message header, and delivers payload words to the DUT side over valid/ready with sop/eop framing.
- It returns the 64-bit read count, rdCnt, to the host as the credit for freed slots.

---
 rtl/ixc_sfifo_reader.sv | 128 ++++++++++++
 tb/tb_ixc_sfifo_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ixc_sfifo_reader.sv
// ixc_sfifo_reader: consumer end of the host-to-DUT stream FIFO; parses headers and
// delivers payload over valid/ready with sop/eop framing, returning rdCnt as credit.
module ixc_sfifo_reader #(
    parameter int DW      = 64,
    parameter int AW      = 10,
    parameter int MAX_LEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [63:0]   wrCnt,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          msg_valid,
    input  logic          msg_ready,
    output logic [DW-1:0] msg_data,
    output logic          msg_sop,
    output logic          msg_eop,
    output logic [7:0]    msg_chan,
    output logic [63:0]   rdCnt,
    output logic          err_len,
    output logic          err_ovf,
    output logic [15:0]   drop_cnt
);
    localparam logic [63:0] DEPTH = 64'(1) << AW;

    typedef enum logic [1:0] {HDR, PAY, HALT} state_t;

    state_t        state, state_nx;
    logic          inflight;
    logic [15:0]   remaining, rem_nx;
    logic [7:0]    chan_r;
    logic          first;
    logic [DW-1:0] sk_data [2];
    logic          sk_sop  [2];
    logic          sk_eop  [2];
    logic [7:0]    sk_chan [2];
    logic          wp, rp;
    logic [1:0]    count;
    logic [63:0]   avail;
    logic [15:0]   hdr_len;
    logic          push, pop, room;

    assign hdr_len   = mem_rdata[15:0];
    assign msg_valid = count != 2'd0;
    assign msg_data  = sk_data[rp];
    assign msg_sop   = sk_sop[rp];
    assign msg_eop   = sk_eop[rp];
    assign msg_chan  = sk_chan[rp];

    // Room is judged on occupancy after this cycle's transfer, so a stream sustains one word per cycle.
    always_comb begin
        avail     = wrCnt - rdCnt - 64'(inflight);
        mem_raddr = rdCnt[AW-1:0] + AW'(inflight);
        push      = inflight && state == PAY;
        pop       = msg_valid && msg_ready;
        room      = (state == HDR && !inflight) || (({1'b0, count} + 3'(push) - 3'(pop)) < 3'd2);
        mem_ren   = !rst && enable && avail != 64'd0 && state != HALT && room;
    end

    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        if (inflight) begin
            case (state)
                HDR: begin
                    state_nx = hdr_len == 16'd0 ? HDR : hdr_len > 16'(MAX_LEN) ? HALT : PAY;
                    rem_nx   = hdr_len;
                end
                PAY: begin
                    rem_nx   = remaining - 16'd1;
                    state_nx = remaining == 16'd1 ? HDR : PAY;
                end
                default: state_nx = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HDR;
            inflight  <= 1'b0;
            remaining <= '0;
            chan_r    <= '0;
            first     <= 1'b0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            count     <= '0;
            rdCnt     <= '0;
            err_len   <= 1'b0;
            err_ovf   <= 1'b0;
            drop_cnt  <= '0;
            for (int i = 0; i < 2; i++) begin
                sk_data[i] <= '0;
                sk_sop[i]  <= 1'b0;
                sk_eop[i]  <= 1'b0;
                sk_chan[i] <= '0;
            end
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            inflight  <= mem_ren;
            rdCnt     <= rdCnt + 64'(inflight);
            count     <= count + 2'(push) - 2'(pop);
            if (inflight && state == HDR) begin
                chan_r <= mem_rdata[23:16];
                first  <= 1'b1;
                if (hdr_len == 16'd0 && drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
                if (hdr_len > 16'(MAX_LEN))
                    err_len <= 1'b1;
            end
            if (push) begin
                sk_data[wp] <= mem_rdata;
                sk_sop[wp]  <= first;
                sk_eop[wp]  <= remaining == 16'd1;
                sk_chan[wp] <= chan_r;
                wp          <= ~wp;
                first       <= 1'b0;
            end
            if (pop)
                rp <= ~rp;
            if (wrCnt - rdCnt > DEPTH)
                err_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ixc_sfifo_reader.sv
// tb_ixc_sfifo_reader: table-driven messages through a host memory model, plus
// directed sequences for partial data, enable, address wrap, length error, overflow and reset.
module tb_ixc_sfifo_reader;
    localparam int AW = 10;
    localparam int DEPTH = 1024;
    localparam int MAX_LEN = 256;

    logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, msg_ready = 1'b0;
    logic [63:0]   wrCnt = '0, mem_rdata = '0;
    logic          mem_ren, msg_valid, msg_sop, msg_eop, err_len, err_ovf;
    logic [AW-1:0] mem_raddr;
    logic [63:0]   msg_data, rdCnt;
    logic [7:0]    msg_chan;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    ixc_sfifo_reader #(.DW(64), .AW(AW), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wrCnt(wrCnt),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .msg_sop(msg_sop), .msg_eop(msg_eop), .msg_chan(msg_chan),
        .rdCnt(rdCnt), .err_len(err_len), .err_ovf(err_ovf), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [7:0]  chan;
    } beat_t;

    typedef struct {
        logic [7:0]  ch;
        int          len;
        logic [63:0] base;
        int          mode;
        longint      rd;
        int          drop;
    } vec_t;

    logic [63:0]   mem [DEPTH];
    beat_t         exp_q [$];
    logic [AW-1:0] raddr_q [$];
    vec_t          tv [8];
    longint        wp = 0;
    int            nvec = 0, nerr = 0, cyc = 0, sop_cyc = 0, eop_cyc = 0, rmode = 0;
    bit            rec = 1'b0;
    logic          pv = 1'b0, pr = 1'b0;
    logic [73:0]   pb = '0;

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       msg_ready = 1'b1;
            1:       msg_ready = (cyc % 3 == 0);
            2:       msg_ready = 1'($urandom_range(0, 1));
            default: msg_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) pv = 1'b0;
        else begin
            if (pv && !pr) begin
                chk("hold_valid", 80'(msg_valid), 80'd1);
                chk("hold_beat", 80'({msg_data, msg_sop, msg_eop, msg_chan}), 80'(pb));
            end
            if (rec && mem_ren) raddr_q.push_back(mem_raddr);
            if (msg_valid && msg_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL extra_word: got %0h expected none", msg_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 80'(msg_data), 80'(e.data));
                    chk("sop", 80'(msg_sop), 80'(e.sop));
                    chk("eop", 80'(msg_eop), 80'(e.eop));
                    chk("chan", 80'(msg_chan), 80'(e.chan));
                end
                if (msg_sop) sop_cyc = cyc;
                if (msg_eop) eop_cyc = cyc;
            end
            pv = msg_valid;
            pr = msg_ready;
            pb = {msg_data, msg_sop, msg_eop, msg_chan};
        end
    end

    task automatic put(input logic [63:0] w);
        mem[wp[AW-1:0]] = w;
        wp++;
    endtask

    task automatic send_msg(input logic [7:0] ch, input int len, input logic [63:0] base, input bit pub);
        put({40'hDEADBEEFAA, ch, 16'(len)});
        for (int i = 0; i < len; i++) begin
            put(base + 64'(i));
            if (len <= MAX_LEN) exp_q.push_back('{base + 64'(i), i == 0, i == len - 1, ch});
        end
        if (pub) wrCnt = 64'(wp);
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            if (exp_q.size() == 0 && rdCnt == 64'(wp) && !msg_valid) break;
            @(negedge clk);
        end
        if (i == 4000) begin
            nvec++; nerr++;
            $display("FAIL %s_timeout: got rdCnt %0d expected %0d", name, rdCnt, wp);
        end
    endtask

    initial begin
        int rem, l;
        logic any_ren;
        tv[0] = '{8'h03, 4,   64'hA0, 0, 5,   0};
        tv[1] = '{8'h03, 4,   64'hB0, 1, 10,  0};
        tv[2] = '{8'h07, 0,   64'h0,  0, 11,  1};
        tv[3] = '{8'h07, 0,   64'h0,  0, 12,  2};
        tv[4] = '{8'h07, 0,   64'h0,  0, 13,  3};
        tv[5] = '{8'h01, 1,   64'hC0, 0, 15,  3};
        tv[6] = '{8'h55, 256, 64'h1000, 2, 272, 3};
        tv[7] = '{8'h09, 2,   64'hD0, 0, 275, 3};

        repeat (2) @(negedge clk);
        chk("rst_valid", 80'(msg_valid), 80'd0);
        chk("rst_ren", 80'(mem_ren), 80'd0);
        chk("rst_rdcnt", 80'(rdCnt), 80'd0);
        chk("rst_errs", 80'({err_len, err_ovf}), 80'd0);
        chk("rst_drop", 80'(drop_cnt), 80'd0);
        chk("rst_data", 80'(msg_data), 80'd0);
        @(posedge clk); #1 rst = 1'b0; enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rmode = tv[i].mode;
            send_msg(tv[i].ch, tv[i].len, tv[i].base, 1'b1);
            drain("vec");
            chk("vec_rdcnt", 80'(rdCnt), 80'(tv[i].rd));
            chk("vec_drop", 80'(drop_cnt), 80'(tv[i].drop));
            if (tv[i].mode == 0 && tv[i].len > 0)
                chk("vec_burst", 80'(eop_cyc - sop_cyc), 80'(tv[i].len - 1));
        end

        rmode = 0;
        send_msg(8'h04, 3, 64'hE0, 1'b0);
        wrCnt = 64'(wp - 2);
        repeat (10) @(negedge clk);
        chk("partial_valid", 80'(msg_valid), 80'd0);
        chk("partial_rdcnt", 80'(rdCnt), 80'd277);
        wrCnt = 64'(wp);
        drain("partial");
        chk("partial_done", 80'(rdCnt), 80'd279);

        enable = 1'b0;
        send_msg(8'h05, 3, 64'hF0, 1'b1);
        repeat (8) @(negedge clk);
        chk("en_rdcnt", 80'(rdCnt), 80'd279);
        chk("en_ren", 80'(mem_ren), 80'd0);
        enable = 1'b1;
        drain("enable");
        chk("en_done", 80'(rdCnt), 80'd283);

        while (wp % DEPTH != 1020) begin
            rem = 1020 - int'(wp % DEPTH);
            l = rem - 1 > 256 ? 256 : rem - 1;
            send_msg(8'hE0, l, 64'h2000, 1'b1);
            drain("pad");
        end
        raddr_q.delete();
        rec = 1'b1;
        send_msg(8'h66, 5, 64'h3000, 1'b1);
        drain("wrap");
        rec = 1'b0;
        chk("wrap_rdcnt", 80'(rdCnt), 80'd1026);
        chk("wrap_nreads", 80'(raddr_q.size()), 80'd6);
        for (int i = 0; i < 6 && i < raddr_q.size(); i++)
            chk("wrap_raddr", 80'(raddr_q[i]), 80'((1020 + i) % DEPTH));

        put({40'h0, 8'h11, 16'd300});
        wrCnt = 64'(wp);
        repeat (5) @(negedge clk);
        chk("len_err", 80'(err_len), 80'd1);
        chk("len_rdcnt", 80'(rdCnt), 80'd1027);
        for (int i = 0; i < 5; i++) put(64'h77);
        wrCnt = 64'(wp);
        any_ren = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_ren |= mem_ren;
        end
        chk("halt_ren", 80'(any_ren), 80'd0);
        chk("halt_rdcnt", 80'(rdCnt), 80'd1027);
        #2 rst = 1'b1;
        #1 chk("len_clr", 80'({err_len, rdCnt}), 80'd0);
        wrCnt = '0; wp = 0; exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;

        rmode = 3;
        send_msg(8'h02, 4, 64'h5000, 1'b1);
        repeat (8) @(negedge clk);
        chk("stall_beat", 80'({msg_valid, msg_sop, msg_chan, msg_data}), {6'd0, 1'b1, 1'b1, 8'h02, 64'h5000});
        chk("ovf_pre", 80'(err_ovf), 80'd0);
        enable = 1'b0;
        wrCnt = 64'(wp + DEPTH + 1);
        @(negedge clk);
        chk("ovf_set", 80'(err_ovf), 80'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_flags", 80'({msg_valid, mem_ren, msg_sop, msg_eop, err_len, err_ovf}), 80'd0);
        chk("arst_cnts", 80'({rdCnt, drop_cnt}), 80'd0);
        chk("arst_data", 80'({msg_data, msg_chan, mem_raddr}), 80'd0);
        exp_q.delete();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
